// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared types and constants for the Z80 bus controller
package z80_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_RD,
        S_MEM_WAITST,
        S_IO,
        S_HOLD
    } bus_state_t;

    localparam logic [7:0] INT_VECTOR_DEFAULT = 8'hFF;

endpackage

// File: rtl/z80_wait_counter.sv
// rtl/z80_wait_counter.sv - loadable saturating down-counter with zero flag
module z80_wait_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    assign done = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !done) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/z80_bus_ctrl.sv
// rtl/z80_bus_ctrl.sv - Z80 strobe decoder driving an SRAM port and a handshaked I/O port
module z80_bus_ctrl
    import z80_bus_pkg::*;
#(
    parameter int         MEM_WAIT   = 0,
    parameter int         IO_TIMEOUT = 15,
    parameter logic [7:0] INT_VECTOR = INT_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_out,
    input  logic [7:0]  cpu_wdata,
    input  logic        M1_L,
    input  logic        MREQ_L,
    input  logic        IORQ_L,
    input  logic        RD_L,
    input  logic        WR_L,
    input  logic        RFSH_L,
    output logic [7:0]  data_in,
    output logic        WAIT_L,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_req,
    output logic        io_we,
    input  logic        io_ack,
    input  logic [7:0]  io_rdata,
    output logic        io_timeout
);

    localparam int TW = (IO_TIMEOUT > 0) ? $clog2(IO_TIMEOUT + 1) : 1;
    localparam int CW = (TW > 3) ? TW : 3;
    localparam logic [CW-1:0] TO_LOAD = CW'(IO_TIMEOUT);
    localparam logic [CW-1:0] MW_LOAD = CW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);

    bus_state_t    state, state_d;
    logic [7:0]    data_in_d, rd_buf, rd_buf_d;
    logic          wait_l_d, mem_re_d, mem_we_d;
    logic [15:0]   mem_addr_d;
    logic [7:0]    mem_wdata_d, io_addr_d, io_wdata_d;
    logic          io_req_d, io_we_d, io_timeout_d;
    logic          cnt_load, cnt_en, cnt_done;
    logic [CW-1:0] cnt_val;

    z80_wait_counter #(.W(CW)) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    always_comb begin
        state_d      = state;
        data_in_d    = data_in;
        rd_buf_d     = rd_buf;
        wait_l_d     = WAIT_L;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        io_addr_d    = io_addr;
        io_wdata_d   = io_wdata;
        io_req_d     = io_req;
        io_we_d      = io_we;
        io_timeout_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_en       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!RFSH_L) begin
                    state_d = S_IDLE;
                end else if (!M1_L && !IORQ_L) begin
                    data_in_d = INT_VECTOR;
                    state_d   = S_HOLD;
                end else if (!MREQ_L && !RD_L) begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = addr_out;
                    wait_l_d   = 1'b0;
                    state_d    = S_MEM_RD;
                end else if (!MREQ_L && !WR_L) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_out;
                    mem_wdata_d = cpu_wdata;
                    state_d     = S_HOLD;
                end else if (!IORQ_L && M1_L && (!RD_L || !WR_L)) begin
                    io_req_d   = 1'b1;
                    io_addr_d  = addr_out[7:0];
                    io_wdata_d = cpu_wdata;
                    io_we_d    = !WR_L;
                    wait_l_d   = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_val    = TO_LOAD;
                    state_d    = S_IO;
                end
            end
            S_MEM_RD: begin
                // First cycle here is the SRAM's own read cycle; data lands on the next.
                if (!mem_re) begin
                    if (MEM_WAIT == 0) begin
                        data_in_d = mem_rdata;
                        wait_l_d  = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        rd_buf_d = mem_rdata;
                        cnt_load = 1'b1;
                        cnt_val  = MW_LOAD;
                        state_d  = S_MEM_WAITST;
                    end
                end
            end
            S_MEM_WAITST: begin
                if (cnt_done) begin
                    data_in_d = rd_buf;
                    wait_l_d  = 1'b1;
                    state_d   = S_HOLD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_IO: begin
                // Ack is checked before the limit so a last-cycle ack still completes.
                if (io_ack) begin
                    io_req_d = 1'b0;
                    if (!io_we) data_in_d = io_rdata;
                    wait_l_d = 1'b1;
                    state_d  = S_HOLD;
                end else if (cnt_done) begin
                    io_req_d     = 1'b0;
                    io_timeout_d = 1'b1;
                    if (!io_we) data_in_d = 8'hFF;
                    wait_l_d     = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_HOLD: begin
                if (MREQ_L && IORQ_L && RD_L && WR_L) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            data_in    <= 8'h00;
            rd_buf     <= 8'h00;
            WAIT_L     <= 1'b1;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_wdata  <= 8'h00;
            io_addr    <= 8'h00;
            io_wdata   <= 8'h00;
            io_req     <= 1'b0;
            io_we      <= 1'b0;
            io_timeout <= 1'b0;
        end else begin
            state      <= state_d;
            data_in    <= data_in_d;
            rd_buf     <= rd_buf_d;
            WAIT_L     <= wait_l_d;
            mem_re     <= mem_re_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            io_addr    <= io_addr_d;
            io_wdata   <= io_wdata_d;
            io_req     <= io_req_d;
            io_we      <= io_we_d;
            io_timeout <= io_timeout_d;
        end
    end

endmodule
